// File: rtl/add_share_sched.sv
// add_share_sched: round-robin scheduler sharing one external 8-bit adder slice
// between two requesters, sequencing multi-byte additions byte-serially with
// the carry chained through a register between cycles.
// Optional feature macro: ADDSCHED_SUB_EN (adds req_sub, A-B via ~B and cin=1).
module add_share_sched #(
  parameter int NBYTES = 4,
  localparam int LW = $clog2(NBYTES),
  localparam int W  = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*W-1:0]    req_a,
  input  logic [2*W-1:0]    req_b,
  input  logic [2*LW-1:0]   req_len,
`ifdef ADDSCHED_SUB_EN
  input  logic [1:0]        req_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_cin,
  input  logic [7:0]        add_sum,
  input  logic              add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t          state, state_nx;
  logic            lp;
  logic            id_r;
  logic [W-1:0]    a_r, b_r, result;
  logic [LW-1:0]   len_r, idx;
  logic            carry;
  logic            sub_r;
  logic            gnt_id;
  logic [LW-1:0]   len_sel, len_clamp;
  logic            sub_sel;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_id    = req_valid[1];
    if (req_valid == 2'b11) gnt_id = ~lp;
    req_ready = '0;
    if (state == IDLE && |req_valid) req_ready = gnt_id ? 2'b10 : 2'b01;
    len_sel   = req_len[gnt_id*LW +: LW];
    len_clamp = ({1'b0, len_sel} >= (LW+1)'(NBYTES)) ? LW'(NBYTES - 1) : len_sel;
`ifdef ADDSCHED_SUB_EN
    sub_sel   = req_sub[gnt_id];
`else
    sub_sel   = 1'b0;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (|req_valid) state_nx = RUN;
      RUN:  if (idx == len_r) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, operand capture and byte-serial result/carry accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lp     <= 1'b1;
      id_r   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      len_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      sub_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (|req_valid) begin
          a_r    <= req_a[gnt_id*W +: W];
          b_r    <= req_b[gnt_id*W +: W];
          len_r  <= len_clamp;
          sub_r  <= sub_sel;
          id_r   <= gnt_id;
          lp     <= gnt_id;
          idx    <= '0;
          carry  <= 1'b0;
          result <= '0;
        end
        RUN: begin
          result[8*idx +: 8] <= add_sum;
          carry              <= add_cout;
          if (idx != len_r) idx <= idx + LW'(1);
        end
        default: ;
      endcase
    end
  end

  // Adder pins are only driven during RUN; subtraction inverts B and forces cin on byte 0.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_r[8*idx +: 8];
      add_b   = sub_r ? ~b_r[8*idx +: 8] : b_r[8*idx +: 8];
      add_cin = (idx == '0) ? sub_r : carry;
    end
  end

  // Response fields come straight from held registers so they stay stable in RESP.
  always_comb begin
    rsp_valid = (state == RESP);
    rsp_id    = id_r;
    rsp_sum   = result;
    rsp_cout  = carry;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_add_share_sched.sv
// Directed self-checking bench for add_share_sched (NBYTES=4); the bench
// supplies the combinational 8-bit adder the block is meant to share.
module tb_add_share_sched;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] a0, a1, b0, b1;
  logic [1:0]  l0, l1;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [31:0] rsp_sum;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
`ifdef ADDSCHED_SUB_EN
  logic [1:0]  req_sub;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] hold_sum;

  assign req_a   = {a1, a0};
  assign req_b   = {b1, b0};
  assign req_len = {l1, l0};
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  add_share_sched #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_len(req_len),
`ifdef ADDSCHED_SUB_EN
    .req_sub(req_sub),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; l0 = '0; l1 = '0;
`ifdef ADDSCHED_SUB_EN
    req_sub = '0;
`endif
    cyc(); cyc();
    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_add",       64'({add_a, add_b, add_cin}), 64'd0);
    rst = 1'b0;
    cyc();

    // Single add with carry into byte 1
    a0 = 32'h000000FF; b0 = 32'h00000001; l0 = 2'd1; req_valid = 2'b01;
    #1 chk("t1_req_ready", 64'(req_ready), 64'd1);
    cyc();                                   // T+1: RUN idx0
    req_valid = '0;
    chk("t1_busy",  64'(busy), 64'd1);
    chk("t1_b0_pins", 64'({add_a, add_b, add_cin}), 64'({8'hFF, 8'h01, 1'b0}));
    chk("t1_rdy_run", 64'(req_ready), 64'd0);
    cyc();                                   // T+2: RUN idx1
    chk("t1_b1_pins", 64'({add_a, add_b, add_cin}), 64'({8'h00, 8'h00, 1'b1}));
    chk("t1_novalid", 64'(rsp_valid), 64'd0);
    cyc();                                   // T+3: RESP
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_sum",   64'(rsp_sum),   64'h100);
    chk("t1_cout",  64'(rsp_cout),  64'd0);
    chk("t1_id",    64'(rsp_id),    64'd0);
    rsp_ready = 1'b1;
    cyc();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_pins", 64'({add_a, add_b, add_cin}), 64'd0);
    rsp_ready = 1'b0;

    // Full-width carry chain, then backpressure in RESP
    a0 = 32'hFFFFFFFF; b0 = 32'h00000001; l0 = 2'd3; req_valid = 2'b01;
    #1 chk("t2_req_ready", 64'(req_ready), 64'd1);
    cyc(); req_valid = '0;                   // T+1
    cyc(); cyc(); cyc();                     // T+4: last RUN
    chk("t2_novalid", 64'(rsp_valid), 64'd0);
    cyc();                                   // T+5: RESP
    chk("t2_valid", 64'(rsp_valid), 64'd1);
    chk("t2_sum",   64'(rsp_sum),   64'h0);
    chk("t2_cout",  64'(rsp_cout),  64'd1);
    hold_sum = rsp_sum;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum",   64'(rsp_sum),   64'(hold_sum));
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy",  64'(busy),      64'd1);
      cyc();
    end
    rsp_ready = 1'b1; req_valid = '0;
    #1 chk("bp_rdy_resp", 64'(req_ready), 64'd0);
    cyc();
    chk("bp_release_valid", 64'(rsp_valid), 64'd0);
    chk("bp_release_busy",  64'(busy),      64'd0);
    rsp_ready = 1'b0;

    // Reset mid-RUN: requester 0 granted alone (lp=0), then aborted
    a0 = 32'h12345678; b0 = 32'h11111111; l0 = 2'd3; req_valid = 2'b01;
    cyc(); req_valid = '0;                   // T+1
    cyc();                                   // T+2
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rr_busy",  64'(busy), 64'd0);
    chk("rr_valid", 64'(rsp_valid), 64'd0);
    chk("rr_sum",   64'({rsp_sum, rsp_cout, rsp_id}), 64'd0);
    chk("rr_pins",  64'({add_a, add_b, add_cin}), 64'd0);
    rsp_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("rr_noresp", 64'(rsp_valid), 64'd0);

    // Contention: both valid, len=0, rsp_ready=1 -> grants 0,1,0,1 every 3 cycles
    a0 = 32'hAA000010; b0 = 32'h00000020; l0 = 2'd0;
    a1 = 32'h000000F0; b1 = 32'h00000015; l1 = 2'd0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("ct_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      cyc();
      chk("ct_run_rdy", 64'(req_ready), 64'd0);
      cyc();
      chk("ct_valid", 64'(rsp_valid), 64'd1);
      chk("ct_id",    64'(rsp_id),    64'(k % 2));
      chk("ct_sum",   64'(rsp_sum),   (k % 2 == 0) ? 64'h30 : 64'h05);
      chk("ct_cout",  64'(rsp_cout),  (k % 2 == 0) ? 64'd0 : 64'd1);
      cyc();
    end
    req_valid = '0;
    cyc();

`ifdef ADDSCHED_SUB_EN
    // Subtraction 5 - 7 = -2, borrow (cout=0)
    a0 = 32'h05; b0 = 32'h07; l0 = 2'd0; req_sub = 2'b01; req_valid = 2'b01;
    rsp_ready = 1'b0;
    cyc(); req_valid = '0;
    chk("sub_pins", 64'({add_b, add_cin}), 64'({8'hF8, 1'b1}));
    cyc();
    chk("sub_sum",  64'(rsp_sum),  64'h000000FE);
    chk("sub_cout", 64'(rsp_cout), 64'd0);
    rsp_ready = 1'b1;
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
